// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// burst tag constants and the round-robin owner selection helper.
package wb_arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_M0   = 2'd1;
    localparam logic [1:0] ARB_M1   = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_M0   = ARB_M0,
        ST_M1   = ARB_M1
    } arb_state_t;

    // On a tie the master that did not own the bus last wins; last_owner 1 = m1.
    function automatic arb_state_t rr_pick(input logic m0_cyc, input logic m1_cyc,
                                           input logic last_owner);
        arb_state_t pick;
        pick = ST_IDLE;
        if (m0_cyc && m1_cyc)
            pick = last_owner ? ST_M0 : ST_M1;
        else if (m0_cyc)
            pick = ST_M0;
        else if (m1_cyc)
            pick = ST_M1;
        return pick;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter owner: counts stalled strobe cycles and
// pulses timeout_o on the TIMEOUT_CYCLES-th consecutive stall cycle.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic clr_i,
    input  logic stall_i,
    input  logic resp_i,
    output logic timeout_o
);

    logic [7:0] count_reg;
    logic [7:0] count_next;
    logic [7:0] count_inc;

    assign count_inc = count_reg + 8'd1;
    // The pulse cycle is itself the last stall cycle being counted.
    assign timeout_o = stall_i && (count_inc == 8'(TIMEOUT_CYCLES));

    always_comb begin
        count_next = count_reg;
        if (clr_i || resp_i || timeout_o)
            count_next = 8'd0;
        else if (stall_i)
            count_next = count_inc;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i)
            count_reg <= 8'd0;
        else
            count_reg <= count_next;
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master to one-slave Wishbone B3 arbiter, round-robin with cycle lock.
// Define WB_ARB_TIMEOUT_EN to add the stall watchdog and timeout_o.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk_i,
    input  logic            nrst_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,

`ifdef WB_ARB_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic [1:0]      grant_o
);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       last_owner_reg;

    logic own_m0;
    logic own_m1;
    logic own_cyc;
    logic own_stb;
    logic timeout;

    // The owner is released only on the cycle its cyc is low; that same cycle
    // picks the successor so there is no idle bubble on handover.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_M0:   if (!m0_cyc_i) state_next = rr_pick(m0_cyc_i, m1_cyc_i, last_owner_reg);
            ST_M1:   if (!m1_cyc_i) state_next = rr_pick(m0_cyc_i, m1_cyc_i, last_owner_reg);
            default: state_next = rr_pick(m0_cyc_i, m1_cyc_i, last_owner_reg);
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (state_next == ST_M0 && state_reg != ST_M0)
                last_owner_reg <= 1'b0;
            else if (state_next == ST_M1 && state_reg != ST_M1)
                last_owner_reg <= 1'b1;
        end
    end

    assign own_m0  = (state_reg == ST_M0);
    assign own_m1  = (state_reg == ST_M1);
    assign own_cyc = (own_m0 && m0_cyc_i) || (own_m1 && m1_cyc_i);
    assign own_stb = (own_m0 && m0_stb_i) || (own_m1 && m1_stb_i);
    assign grant_o = {own_m1, own_m0};

    assign s_adr_o = own_m1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = own_m1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = own_m1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = own_cyc && (own_m1 ? m1_we_i : m0_we_i);
    assign s_cti_o = own_m1 ? m1_cti_i : m0_cti_i;
    assign s_bte_o = own_m1 ? m1_bte_i : m0_bte_i;
    assign s_cyc_o = own_cyc;
    assign s_stb_o = own_stb && !timeout;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Responses only reach an owner that still holds cyc, so a straggling
    // ack after a dropped cycle is never misattributed.
    assign m0_ack_o = own_m0 && m0_cyc_i && s_ack_i;
    assign m0_rty_o = own_m0 && m0_cyc_i && s_rty_i;
    assign m0_err_o = own_m0 && ((m0_cyc_i && s_err_i) || timeout);
    assign m1_ack_o = own_m1 && m1_cyc_i && s_ack_i;
    assign m1_rty_o = own_m1 && m1_cyc_i && s_rty_i;
    assign m1_err_o = own_m1 && ((m1_cyc_i && s_err_i) || timeout);

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_clr;
    logic wd_stall;
    logic wd_resp;

    assign wd_clr   = (state_reg == ST_IDLE) || (state_next != state_reg);
    assign wd_resp  = own_cyc && (s_ack_i || s_err_i || s_rty_i);
    assign wd_stall = own_cyc && own_stb && !(s_ack_i || s_err_i || s_rty_i);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .clr_i    (wd_clr),
        .stall_i  (wd_stall),
        .resp_i   (wd_resp),
        .timeout_o(timeout)
    );

    assign timeout_o = timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: reset, single read, tie-break,
// round-robin, burst lock, error passthrough, async reset, optional watchdog.
module tb_wb_master_arbiter;
    import wb_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          nrst_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    grant_o;
`ifdef WB_ARB_TIMEOUT_EN
    logic          timeout_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_master_arbiter #(
        .AW(AW),
        .DW(DW)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_we_i (m0_we_i),  .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_we_i (m1_we_i),  .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o (s_adr_o),  .s_dat_o (s_dat_o),  .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),   .s_cyc_o (s_cyc_o),  .s_stb_o (s_stb_o),
        .s_cti_o (s_cti_o),  .s_bte_o (s_bte_o),  .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),  .s_err_i (s_err_i),  .s_rty_i (s_rty_i),
`ifdef WB_ARB_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .grant_o (grant_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC; m0_bte_i = 2'b00;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = CTI_CLASSIC; m1_bte_i = 2'b00;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        nrst_i = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        nrst_i = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        logic [1:0] exp_grant;
        int         m0_grants;
        int         m1_grants;

        // ---------------- reset state ----------------
        nrst_i = 1'b0;
        clear_inputs();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_acks",  32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'h0);
        $display("txn reset: grant=%b s_cyc=%b", grant_o, s_cyc_o);
        do_reset();

        // ---------------- single m0 read ----------------
        m0_adr_i = 32'h0000_0040; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk_i);
        check("rd_c0_grant", 32'(grant_o), 32'h0);
        check("rd_c0_s_cyc", 32'(s_cyc_o), 32'h0);
        step();
        @(negedge clk_i);
        check("rd_c1_grant", 32'(grant_o), 32'h1);
        check("rd_c1_s_stb", 32'(s_stb_o), 32'h1);
        check("rd_c1_s_adr", s_adr_o, 32'h0000_0040);
        check("rd_c1_m0_ack", 32'(m0_ack_o), 32'h0);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("rd_c2_m0_ack", 32'(m0_ack_o), 32'h1);
        check("rd_c2_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("rd_c2_m1_ack", 32'(m1_ack_o), 32'h0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("rd_c3_s_cyc", 32'(s_cyc_o), 32'h0);
        step();
        // A straggling ack while idle must reach nobody.
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("rd_c4_grant", 32'(grant_o), 32'h0);
        check("rd_late_ack", 32'({m0_ack_o, m1_ack_o}), 32'h0);
        $display("txn single_read: dat=0x%0h", m0_dat_o);
        step();
        s_ack_i = 1'b0;

        // ---------------- simultaneous request from reset ----------------
        do_reset();
        m0_adr_i = 32'h10; m1_adr_i = 32'h20;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("tie_first_grant", 32'(grant_o), 32'h1);
        check("tie_first_adr", s_adr_o, 32'h10);
        check("tie_m1_waits", 32'(m1_ack_o), 32'h0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("tie_drop_grant", 32'(grant_o), 32'h1);
        step();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("tie_handover_grant", 32'(grant_o), 32'h2);
        check("tie_handover_adr", s_adr_o, 32'h20);
        check("tie_m1_ack", 32'(m1_ack_o), 32'h1);
        check("tie_m0_no_ack", 32'(m0_ack_o), 32'h0);
        $display("txn tie_break: second grant=%b", grant_o);
        step();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();

        // ---------------- round-robin fairness ----------------
        // last owner is m1 here, so m0 leads the alternation.
        m0_grants = 0; m1_grants = 0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int t = 0; t < 8; t++) begin
            step();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            s_ack_i = 1'b1;
            exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk_i);
            check($sformatf("rr_grant_%0d", t), 32'(grant_o), 32'(exp_grant));
            check($sformatf("rr_acks_%0d", t), 32'({m1_ack_o, m0_ack_o}), 32'(exp_grant));
            if (grant_o == 2'b01) m0_grants++;
            if (grant_o == 2'b10) m1_grants++;
            $display("txn rr_%0d: grant=%b", t, grant_o);
            step();
            s_ack_i = 1'b0;
            if (exp_grant == 2'b01) begin
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end else begin
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end
        end
        check("rr_m0_total", 32'(m0_grants), 32'd4);
        check("rr_m1_total", 32'(m1_grants), 32'd4);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        repeat (3) step();

        // ---------------- burst lock ----------------
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h100; m1_cti_i = CTI_INCR;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h900; m0_cti_i = CTI_CLASSIC;
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 32'h100 + 32'(4 * i);
            m1_cti_i = (i < 3) ? CTI_INCR : CTI_EOB;
            s_ack_i = 1'b1;
            @(negedge clk_i);
            check($sformatf("burst_grant_%0d", i), 32'(grant_o), 32'h2);
            check($sformatf("burst_adr_%0d", i), s_adr_o, 32'h100 + 32'(4 * i));
            check($sformatf("burst_cti_%0d", i), 32'(s_cti_o), (i < 3) ? 32'(CTI_INCR) : 32'(CTI_EOB));
            check($sformatf("burst_m0_stall_%0d", i), 32'(m0_ack_o), 32'h0);
            $display("txn burst_beat_%0d: adr=0x%0h cti=%b", i, s_adr_o, s_cti_o);
            step();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);
        check("burst_release_grant", 32'(grant_o), 32'h2);
        step();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("burst_m0_grant", 32'(grant_o), 32'h1);
        check("burst_m0_adr", s_adr_o, 32'h900);
        check("burst_m0_ack", 32'(m0_ack_o), 32'h1);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        repeat (2) step();

        // ---------------- slave error passthrough ----------------
        m0_adr_i = 32'h2000; m0_dat_i = 32'h1234_5678; m0_sel_i = 4'hF; m0_we_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        s_err_i = 1'b1;
        @(negedge clk_i);
        check("err_grant", 32'(grant_o), 32'h1);
        check("err_s_we", 32'(s_we_o), 32'h1);
        check("err_s_dat", s_dat_o, 32'h1234_5678);
        check("err_m0_err", 32'(m0_err_o), 32'h1);
        check("err_m0_ack", 32'(m0_ack_o), 32'h0);
        check("err_m1_err", 32'(m1_err_o), 32'h0);
        step();
        s_err_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        @(negedge clk_i);
        check("err_pulse_end", 32'(m0_err_o), 32'h0);
        $display("txn slave_err: adr=0x2000");
        repeat (2) step();

        // ---------------- asynchronous reset mid-transfer ----------------
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
        step();
        @(negedge clk_i);
        check("arst_pre_grant", 32'(grant_o), 32'h2);
        #2;
        nrst_i = 1'b0;
        #1;
        check("arst_grant", 32'(grant_o), 32'h0);
        check("arst_s_cyc", 32'(s_cyc_o), 32'h0);
        $display("txn async_reset: grant=%b", grant_o);
        do_reset();

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- stall watchdog (TIMEOUT_CYCLES = 16) ----------------
        m0_adr_i = 32'h4000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            @(negedge clk_i);
            check($sformatf("wd_timeout_%0d", k), 32'(timeout_o), (k == 16) ? 32'h1 : 32'h0);
            check($sformatf("wd_err_%0d", k), 32'(m0_err_o), (k == 16) ? 32'h1 : 32'h0);
            check($sformatf("wd_stb_%0d", k), 32'(s_stb_o), (k == 16) ? 32'h0 : 32'h1);
        end
        $display("txn watchdog: stalled 17 cycles");
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        repeat (2) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
